brent_kung_seq_ctrl: RTL and testbench

Sequencing controller that computes WIDTH-bit additions with one shared 8-bit Brent-Kung adder (`brent_kung_8`, ports in1/in2/cin/sum/cout). It processes one byte per clock, LSB first, and chains the carry through an internal register. Operands enter through a valid/ready handshake and the result leaves through one. The block sits between wide-operand producers in the multiplier datapath and the single `brent_kung_8` instance, which it instantiates internally.

---
 rtl/brent_kung_seq_ctrl.sv | 108 ++++++++++
 tb/tb_brent_kung_seq_ctrl.sv | 138 +++++++++++++
 2 files changed

// File: rtl/brent_kung_seq_ctrl.sv
// brent_kung_seq_ctrl: byte-serial WIDTH-bit adder sequenced over one shared 8-bit Brent-Kung adder
module brent_kung_8 (
    input  logic [7:0] in1,
    input  logic [7:0] in2,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);
    logic [7:0] g, p, c;
    logic g0, g10, g32, p32, g54, p54, g76, p76, g30, g74, p74, g70, g50, g20, g40, g60;
    assign g   = in1 & in2;
    assign p   = in1 ^ in2;
    assign g0  = g[0] | (p[0] & cin);
    assign g10 = g[1] | (p[1] & g0);
    assign g32 = g[3] | (p[3] & g[2]);
    assign p32 = p[3] & p[2];
    assign g54 = g[5] | (p[5] & g[4]);
    assign p54 = p[5] & p[4];
    assign g76 = g[7] | (p[7] & g[6]);
    assign p76 = p[7] & p[6];
    assign g30 = g32 | (p32 & g10);
    assign g74 = g76 | (p76 & g54);
    assign p74 = p76 & p54;
    assign g70 = g74 | (p74 & g30);
    assign g50 = g54 | (p54 & g30);
    assign g20 = g[2] | (p[2] & g10);
    assign g40 = g[4] | (p[4] & g30);
    assign g60 = g[6] | (p[6] & g50);
    assign c    = {g60, g50, g40, g30, g20, g10, g0, cin};
    assign sum  = p ^ c;
    assign cout = g70;
endmodule

module brent_kung_seq_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             busy
);
    localparam int N  = WIDTH / 8;
    localparam int IW = N > 1 ? $clog2(N) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_d;
    logic [WIDTH-1:0] a_reg, b_reg, sum_reg;
    logic [IW-1:0] idx;
    logic carry, cout_reg, last, add_cout;
    logic [7:0] add_sum;
    assign last      = idx == IW'(N - 1);
    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign busy      = state != IDLE;
    assign out_sum   = sum_reg;
    assign out_cout  = cout_reg;
    brent_kung_8 u_add (
        .in1 (a_reg[8*idx+:8]),
        .in2 (b_reg[8*idx+:8]),
        .cin (carry),
        .sum (add_sum),
        .cout(add_cout)
    );
    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_d;
    end
    // next-state: accept from IDLE, leave RUN after the top byte, release DONE on out_ready
    always_comb begin
        state_d = state;
        state_d = state == IDLE ? (in_valid ? RUN : IDLE) :
                  state == RUN  ? (last ? DONE : RUN) :
                                  (out_ready ? IDLE : DONE);
    end
    // operand capture and one byte of the sum per RUN cycle, carry chained through a register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg    <= '0;
            b_reg    <= '0;
            sum_reg  <= '0;
            carry    <= 1'b0;
            cout_reg <= 1'b0;
            idx      <= '0;
        end else if (state == IDLE) begin
            if (in_valid) begin
                a_reg    <= in_a;
                b_reg    <= in_b;
                carry    <= in_cin;
                idx      <= '0;
                sum_reg  <= '0;
                cout_reg <= 1'b0;
            end
        end else if (state == RUN) begin
            sum_reg[8*idx+:8] <= add_sum;
            carry             <= add_cout;
            if (last) cout_reg <= add_cout;
            else idx <= idx + 1'b1;
        end
    end
endmodule

// File: tb/tb_brent_kung_seq_ctrl.sv
// tb_brent_kung_seq_ctrl: directed and random checks of the byte-serial adder against arithmetic reference
module tb_brent_kung_seq_ctrl;
    localparam int W = 32;
    localparam int N = W / 8;
    logic clk = 0, rst_n = 0, in_valid = 0, in_cin = 0, out_ready = 0;
    logic [W-1:0] in_a = '0, in_b = '0;
    logic in_ready, out_valid, out_cout, busy;
    logic [W-1:0] out_sum;
    int checks = 0, failures = 0;

    brent_kung_seq_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .out_valid(out_valid),
        .out_ready(out_ready), .out_sum(out_sum), .out_cout(out_cout), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic part_carry(input logic [W-1:0] a, b, input logic c, input int k);
        logic [63:0] m, s;
        m = (64'd1 << (8 * k)) - 1;
        s = ({32'd0, a} & m) + ({32'd0, b} & m) + {63'd0, c};
        return s[8*k];
    endfunction

    task automatic do_op(input logic [W-1:0] a, b, input logic c, input int hold, input string tag);
        logic [63:0] exp;
        logic [W-1:0] held_sum;
        logic held_cout;
        int lat;
        exp = {32'd0, a} + {32'd0, b} + {63'd0, c};
        @(negedge clk);
        in_a = a; in_b = b; in_cin = c; in_valid = 1; out_ready = 0;
        check({tag, "_rdy"}, {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 0; in_a = $urandom; in_b = $urandom; in_cin = 1'($urandom);
        check({tag, "_c0"}, {63'd0, dut.carry}, {63'd0, c});
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (lat <= N) check({tag, "_cy"}, {63'd0, dut.carry}, {63'd0, part_carry(a, b, c, lat)});
        end
        check({tag, "_lat"}, 64'(lat), 64'(N));
        check({tag, "_sum"}, {32'd0, out_sum}, {32'd0, exp[31:0]});
        check({tag, "_cout"}, {63'd0, out_cout}, {63'd0, exp[32]});
        held_sum = out_sum;
        held_cout = out_cout;
        for (int i = 0; i < hold; i++) begin
            in_a = $urandom; in_b = $urandom; in_valid = 1'($urandom);
            @(posedge clk);
            @(negedge clk);
            check({tag, "_hsum"}, {32'd0, out_sum}, {32'd0, held_sum});
            check({tag, "_hcout"}, {63'd0, out_cout}, {63'd0, held_cout});
            check({tag, "_hrdy"}, {62'd0, in_ready, out_valid}, 64'd1);
        end
        in_valid = 0; out_ready = 1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 0;
        check({tag, "_rel"}, {62'd0, in_ready, busy}, 64'd2);
    endtask

    initial begin
        int acc[$];
        int guard;
        logic [W-1:0] ra, rb;
        #2;
        check("rst_rdy", {63'd0, in_ready}, 64'd1);
        check("rst_outs", {61'd0, out_valid, busy, out_cout}, 64'd0);
        check("rst_sum", {32'd0, out_sum}, 64'd0);
        @(negedge clk);
        rst_n = 1;

        do_op(32'h000000FF, 32'h00000001, 1'b0, 0, "t1");
        do_op(32'hFFFFFFFF, 32'h00000000, 1'b1, 0, "t2");
        do_op(32'h12345678, 32'h9ABCDEF0, 1'b0, 0, "t3");
        do_op(32'hDEADBEEF, 32'h0BADF00D, 1'b1, 5, "bp");

        @(negedge clk);
        in_a = 32'h80000000; in_b = 32'h80000000; in_cin = 0; in_valid = 1; out_ready = 1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (in_ready) acc.push_back(cyc);
            if (out_valid) begin
                check("b2b_sum", {32'd0, out_sum}, 64'd0);
                check("b2b_cout", {63'd0, out_cout}, 64'd1);
            end
            @(posedge clk);
            @(negedge clk);
        end
        check("b2b_cnt", 64'(acc.size() >= 2), 64'd1);
        if (acc.size() >= 2) check("b2b_ival", 64'(acc[1] - acc[0]), 64'd6);
        in_valid = 0;
        guard = 0;
        while (busy && guard < 20) begin
            @(posedge clk);
            @(negedge clk);
            guard++;
        end
        check("drain", {63'd0, busy}, 64'd0);
        out_ready = 0;

        @(negedge clk);
        in_a = 32'hCAFEF00D; in_b = 32'h13572468; in_valid = 1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 0;
        #1;
        check("mid_rst_vb", {62'd0, out_valid, busy}, 64'd0);
        check("mid_rst_sum", {32'd0, out_sum}, 64'd0);
        check("mid_rst_rdy", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        rst_n = 1;
        do_op(32'h00000001, 32'h00000001, 1'b0, 0, "post_rst");

        for (int i = 0; i < 25; i++) begin
            ra = $urandom; rb = $urandom;
            if (i % 5 == 0) rb = ~ra;
            do_op(ra, rb, 1'($urandom), int'($urandom_range(0, 3)), "rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
